mem_ctrl512: RTL and testbench

Byte-addressable 512-byte data/instruction memory controller sitting directly downstream of the DataPath. It answers the DataPath's MOV/RW/MAR/OpC request with a registered MOC completion handshake after a programmable number of wait states. It performs MIPS-sized accesses: byte, halfword and word, signed and unsigned loads, big-endian. It flags misaligned or unsupported-size requests without touching storage.

---
 rtl/mem_ctrl512_pkg.sv | 41 ++++
 rtl/mem_ctrl512_if.sv | 17 +
 rtl/mem_ctrl512_byte_ram512.sv | 38 +++
 rtl/mem_ctrl512.sv | 149 ++++++++++++++
 tb/tb_mem_ctrl512.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl512_pkg.sv
// mem_ctrl512_pkg
// Shared definitions for the 512-byte memory controller slice:
//   - FSM state encoding
//   - access size encodings carried in OpC[1:0]
//   - MIPS load/store opcode constants
//   - size_error(): rejects unsupported sizes and misaligned addresses
package mem_ctrl512_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  // size 2'b10 has no meaning and is always rejected
  function automatic logic size_error(input logic [1:0] sz, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_ctrl512_if.sv
// mem_ctrl512_if
// DataPath <-> memory controller handshake bundle.
//   MOV/RW/MAR/OpC/DataIn : request from the DataPath (master drives)
//   DataOut/MOC/ERR       : completion from the controller (slave drives)
interface mem_ctrl512_if #(parameter int ADDR_W = 9);
  logic              MOV;
  logic              RW;
  logic [ADDR_W-1:0] MAR;
  logic [5:0]        OpC;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              MOC;
  logic              ERR;

  modport master (output MOV, RW, MAR, OpC, DataIn, input DataOut, MOC, ERR);
  modport slave  (input MOV, RW, MAR, OpC, DataIn, output DataOut, MOC, ERR);
endinterface

// File: rtl/mem_ctrl512_byte_ram512.sv
// byte_ram512
// Byte-wide storage Mem[0:DEPTH-1] organised as big-endian 4-byte rows.
//   clk   : write clock
//   widx  : word (row) index; the row holds bytes 4*widx .. 4*widx+3
//   rdata : asynchronous read of the row, byte 4*widx in [31:24]
//   wbe   : per-byte write enables, wbe[3] targets byte 4*widx
//   wdata : write data, lanes aligned the same way as rdata
// No reset: contents survive controller reset and can be preloaded hierarchically.
module byte_ram512 #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic [ADDR_W-3:0] widx,
  output logic [31:0]       rdata,
  input  logic [3:0]        wbe,
  input  logic [31:0]       wdata
);

  logic [7:0] Mem [0:DEPTH-1];

  logic [ADDR_W-1:0] a0, a1, a2, a3;

  assign a0 = {widx, 2'b00};
  assign a1 = {widx, 2'b01};
  assign a2 = {widx, 2'b10};
  assign a3 = {widx, 2'b11};

  assign rdata = {Mem[a0], Mem[a1], Mem[a2], Mem[a3]};

  always_ff @(posedge clk) begin
    if (wbe[3]) Mem[a0] <= wdata[31:24];
    if (wbe[2]) Mem[a1] <= wdata[23:16];
    if (wbe[1]) Mem[a2] <= wdata[15:8];
    if (wbe[0]) Mem[a3] <= wdata[7:0];
  end

endmodule

// File: rtl/mem_ctrl512.sv
// mem_ctrl512
// DataPath-facing memory controller: accepts a MOV request, waits
// WAIT_STATES cycles, performs a byte/half/word big-endian access and
// holds MOC (plus ERR on rejection) until MOV drops.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : mem_ctrl512_if slave modport (MOV/RW/MAR/OpC/DataIn in,
//           DataOut/MOC/ERR out)
module mem_ctrl512
  import mem_ctrl512_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 9
) (
  input  logic           clk,
  input  logic           reset,
  mem_ctrl512_if.slave   bus
);

  state_t            state, next_state;
  logic [3:0]        cnt;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        opc_q;
  logic [31:0]       din_q;
  logic              err_q;
  logic [31:0]       dout_q;

  logic              accept, access, req_err, we;
  logic [1:0]        sz, off;
  logic [31:0]       rdata, load_val, wdata;
  logic [3:0]        wbe_raw, wbe;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  assign sz      = opc_q[1:0];
  assign off     = addr_q[1:0];
  assign req_err = size_error(sz, off);
  assign we      = access && !rw_q && !req_err;
  assign wbe     = we ? wbe_raw : 4'b0000;

  assign bus.DataOut = dout_q;
  assign bus.ERR     = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.MOV) next_state = BUSY;
      BUSY:    if (cnt == 4'd0) next_state = DONE;
      DONE:    if (!bus.MOV) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    access  = 1'b0;
    bus.MOC = 1'b0;
    case (state)
      IDLE:    accept  = bus.MOV;
      BUSY:    access  = (cnt == 4'd0);
      DONE:    bus.MOC = 1'b1;
      default: ;
    endcase
  end

  // Request capture, wait countdown and completion registers.
  // A rejected request leaves DataOut alone; stores never touch DataOut.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 4'd0;
      rw_q   <= 1'b0;
      addr_q <= '0;
      opc_q  <= 3'd0;
      din_q  <= 32'd0;
      err_q  <= 1'b0;
      dout_q <= 32'd0;
    end else begin
      if (accept) begin
        rw_q   <= bus.RW;
        addr_q <= bus.MAR;
        opc_q  <= bus.OpC[2:0];
        din_q  <= bus.DataIn;
        cnt    <= 4'(WAIT_STATES);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (access) begin
        err_q <= req_err;
        if (rw_q && !req_err) dout_q <= load_val;
      end else if (state == DONE && !bus.MOV) begin
        err_q <= 1'b0;
      end
    end
  end

  // Load path: pick the addressed lane from the big-endian row, then extend.
  always_comb begin
    byte_sel = 8'h00;
    case (off)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[15:0] : rdata[31:16];
    load_val = rdata;
    case (sz)
      SZ_BYTE: load_val = opc_q[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_val = opc_q[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = rdata;
    endcase
  end

  // Store path: replicate the right-justified data onto every lane and let
  // the byte enables select which lanes land.
  always_comb begin
    wdata   = din_q;
    wbe_raw = 4'b0000;
    case (sz)
      SZ_BYTE: begin
        wdata   = {4{din_q[7:0]}};
        wbe_raw = 4'b1000 >> off;
      end
      SZ_HALF: begin
        wdata   = {2{din_q[15:0]}};
        wbe_raw = off[1] ? 4'b0011 : 4'b1100;
      end
      SZ_WORD: wbe_raw = 4'b1111;
      default: wbe_raw = 4'b0000;
    endcase
  end

  byte_ram512 #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .widx  (addr_q[ADDR_W-1:2]),
    .rdata (rdata),
    .wbe   (wbe),
    .wdata (wdata)
  );

endmodule

// File: tb/tb_mem_ctrl512.sv
// tb_mem_ctrl512
// Directed bench for mem_ctrl512 with a byte-array reference model.
// Inputs change 2 time units after each rising edge; outputs are compared
// on the falling edge.
module tb_mem_ctrl512;
  import mem_ctrl512_pkg::*;

  localparam int WS = 2;

  logic clk;
  logic reset;
  int   cyc;
  int   nChecks;
  int   nFails;

  mem_ctrl512_if #(.ADDR_W(9)) bus ();

  mem_ctrl512 #(.WAIT_STATES(WS), .DEPTH(512), .ADDR_W(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0]  mdl [0:511];
  logic [31:0] curDout;
  logic [31:0] prevDout, newDout;
  logic        txnErr;
  logic        txnActive;
  logic        chkEn;
  int          tStart, tAccess, tDrop;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void modelCompute(input logic rw, input int addr, input logic [5:0] opc,
                                       output logic err, output logic [31:0] val);
    int n;
    case (opc[1:0])
      2'b00:   n = 1;
      2'b01:   n = 2;
      2'b11:   n = 4;
      default: n = 0;
    endcase
    err = (n == 0) ? 1'b1 : ((addr % n) != 0);
    val = 32'd0;
    if (!err && rw) begin
      for (int i = 0; i < n; i++) val = (val << 8) | {24'd0, mdl[addr + i]};
      if (n < 4 && !opc[2] && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
    end
  endfunction

  function automatic void modelStore(input int addr, input logic [5:0] opc, input logic [31:0] din);
    int n;
    n = (opc[1:0] == 2'b00) ? 1 : (opc[1:0] == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) mdl[addr + i] = 8'(din >> (8*(n-1-i)));
  endfunction

  task automatic preload(input int addr, input logic [7:0] v);
    dut.u_ram.Mem[addr] = v;
    mdl[addr] = v;
  endtask

  // Per-cycle comparison against the model's view of the current transaction
  always @(negedge clk) begin
    if (chkEn) begin
      logic        expMoc;
      logic [31:0] expDout;
      if (txnActive) begin
        expMoc  = (cyc >= tAccess) && (cyc < tDrop);
        expDout = (cyc >= tAccess) ? newDout : prevDout;
      end else begin
        expMoc  = 1'b0;
        expDout = curDout;
      end
      checkOutput("cyc_moc", {31'd0, bus.MOC}, {31'd0, expMoc});
      checkOutput("cyc_err", {31'd0, bus.ERR}, {31'd0, expMoc & txnErr});
      checkOutput("cyc_dout", bus.DataOut, expDout);
    end
  end

  // One complete request: raise MOV, wait for MOC, hold MOV for 'extra'
  // further edges, drop MOV and let the controller return to IDLE.
  task automatic applyStimulus(input logic rw, input int addr, input logic [5:0] opc,
                               input logic [31:0] din, input int extra,
                               output int lat, output logic seenErr, output logic [31:0] seenData);
    logic        err;
    logic [31:0] val;
    bit          got;
    modelCompute(rw, addr, opc, err, val);
    lat = -1; seenErr = 1'b0; seenData = 32'd0; got = 0;
    @(posedge clk); #2;
    bus.MOV = 1'b1; bus.RW = rw; bus.MAR = 9'(addr); bus.OpC = opc; bus.DataIn = din;
    tStart   = cyc + 1;
    tAccess  = tStart + WS + 1;
    tDrop    = 32'h7FFF_FFFF;
    txnErr   = err;
    prevDout = curDout;
    newDout  = (rw && !err) ? val : curDout;
    txnActive = 1'b1;
    for (int e = 1; e <= 40 && !got; e++) begin
      @(posedge clk); #2;
      if (bus.MOC) begin
        got = 1; lat = e - 1; seenErr = bus.ERR; seenData = bus.DataOut;
      end
    end
    if (!got) checkOutput("moc_timeout", 32'd0, 32'd1);
    repeat (extra) begin @(posedge clk); #2; end
    bus.MOV = 1'b0;
    tDrop = cyc + 1;
    @(posedge clk); #2;
    checkOutput("moc_clear", {31'd0, bus.MOC}, 32'd0);
    if (!rw && !err) modelStore(addr, opc, din);
    curDout = newDout;
    txnActive = 1'b0;
  endtask

  int          lat;
  logic        e1;
  logic [31:0] d1;

  initial begin
    nChecks = 0; nFails = 0;
    chkEn = 1'b0; txnActive = 1'b0; curDout = 32'd0;
    prevDout = 32'd0; newDout = 32'd0; txnErr = 1'b0;
    tStart = 0; tAccess = 0; tDrop = 0;
    for (int i = 0; i < 512; i++) mdl[i] = 8'h00;
    reset = 1'b0;
    bus.MOV = 1'b0; bus.RW = 1'b1; bus.MAR = 9'd0; bus.OpC = LW; bus.DataIn = 32'd0;

    preload(0, 8'h12); preload(1, 8'h34); preload(2, 8'h56); preload(3, 8'h78);
    preload(4, 8'hFF); preload(5, 8'h80); preload(6, 8'h01); preload(7, 8'h02);
    preload(8, 8'h11); preload(9, 8'h22); preload(10, 8'h33); preload(11, 8'h44);

    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_moc", {31'd0, bus.MOC}, 32'd0);
    checkOutput("reset_err", {31'd0, bus.ERR}, 32'd0);
    checkOutput("reset_dout", bus.DataOut, 32'd0);
    reset = 1'b1;
    @(posedge clk); #2;

    $display("[TB] reset during BUSY");
    bus.MOV = 1'b1; bus.RW = 1'b0; bus.MAR = 9'd8; bus.OpC = SW; bus.DataIn = 32'hDEADBEEF;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checkOutput("rstbusy_moc", {31'd0, bus.MOC}, 32'd0);
    checkOutput("rstbusy_dout", bus.DataOut, 32'd0);
    bus.MOV = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2;
    chkEn = 1'b1;

    applyStimulus(1'b1, 8, LW, 32'd0, 0, lat, e1, d1);
    checkOutput("rstbusy_lw8", d1, 32'h11223344);

    $display("[TB] word load and latency");
    applyStimulus(1'b1, 0, LW, 32'd0, 0, lat, e1, d1);
    checkOutput("lw0_lat", 32'(lat), 32'd3);
    checkOutput("lw0_data", d1, 32'h12345678);

    $display("[TB] signed/unsigned byte and half loads");
    applyStimulus(1'b1, 5, LB, 32'd0, 0, lat, e1, d1);
    checkOutput("lb5", d1, 32'hFFFFFF80);
    applyStimulus(1'b1, 5, LBU, 32'd0, 0, lat, e1, d1);
    checkOutput("lbu5", d1, 32'h00000080);
    applyStimulus(1'b1, 4, LH, 32'd0, 0, lat, e1, d1);
    checkOutput("lh4", d1, 32'hFFFFFF80);

    $display("[TB] halfword store");
    applyStimulus(1'b0, 6, SH, 32'hAAAA5555, 0, lat, e1, d1);
    checkOutput("sh6_err", {31'd0, e1}, 32'd0);
    applyStimulus(1'b1, 4, LW, 32'd0, 0, lat, e1, d1);
    checkOutput("lw4_after_sh", d1, 32'hFF805555);

    $display("[TB] misaligned requests");
    applyStimulus(1'b1, 2, LW, 32'd0, 0, lat, e1, d1);
    checkOutput("lw2_err", {31'd0, e1}, 32'd1);
    checkOutput("lw2_dout_kept", d1, 32'hFF805555);
    applyStimulus(1'b0, 3, SH, 32'h0000BEEF, 0, lat, e1, d1);
    checkOutput("sh3_err", {31'd0, e1}, 32'd1);
    applyStimulus(1'b1, 0, LW, 32'd0, 0, lat, e1, d1);
    checkOutput("lw0_unchanged", d1, 32'h12345678);
    applyStimulus(1'b1, 4, LW, 32'd0, 0, lat, e1, d1);
    checkOutput("lw4_unchanged", d1, 32'hFF805555);

    $display("[TB] MOV held through DONE, then back-to-back");
    applyStimulus(1'b1, 0, LW, 32'd0, 4, lat, e1, d1);
    checkOutput("hold_lw0", d1, 32'h12345678);
    applyStimulus(1'b1, 2, LHU, 32'd0, 0, lat, e1, d1);
    checkOutput("b2b_lat", 32'(lat), 32'd3);
    checkOutput("lhu2", d1, 32'h00005678);

    $display("[TB] byte store");
    applyStimulus(1'b0, 1, SB, 32'h123456AB, 0, lat, e1, d1);
    applyStimulus(1'b1, 0, LW, 32'd0, 0, lat, e1, d1);
    checkOutput("lw0_after_sb", d1, 32'h12AB5678);

    chkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
